// File: rtl/apb3_bridge_controller.sv
// APB-side controller of the AHB-to-APB bridge.
// Sequences one APB3 transfer per qualified AHB request. It handles PREADY
// wait states, propagates PSLVERR, aborts stalled accesses with a watchdog,
// and flags unmapped addresses. Every error source ends in the AHB two-cycle
// ERROR response.
//
// Ports:
//   Hclk, Hresetn        clock, asynchronous active-low reset
//   valid, Hwrite, Haddr qualified AHB request, sampled in IDLE
//   sel                  one-hot slave decode of Haddr (all-zero = unmapped)
//   Hwdata               AHB write data, sampled one cycle after the request
//   Prdata, Pready,      APB3 slave response
//   Pslverr
//   Paddr, Pwdata,       APB3 master outputs
//   Pwrite, Pselx,
//   Penable
//   Hreadyout, Hresp,    AHB response (all outputs are flops)
//   Hrdata
module apb3_bridge_controller #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NUM_SLV = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    input  logic               valid,
    input  logic               Hwrite,
    input  logic [ADDR_W-1:0]  Haddr,
    input  logic [NUM_SLV-1:0] sel,
    input  logic [DATA_W-1:0]  Hwdata,
    input  logic [DATA_W-1:0]  Prdata,
    input  logic               Pready,
    input  logic               Pslverr,
    output logic [ADDR_W-1:0]  Paddr,
    output logic [DATA_W-1:0]  Pwdata,
    output logic               Pwrite,
    output logic [NUM_SLV-1:0] Pselx,
    output logic               Penable,
    output logic               Hreadyout,
    output logic               Hresp,
    output logic [DATA_W-1:0]  Hrdata
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WWAIT  = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_ERR1   = 3'd4;
    localparam logic [2:0] S_ERR2   = 3'd5;

    // Counter is at least one bit wide, so a disabled watchdog still elaborates.
    localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam bit          WDOG_EN  = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [2:0]         state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [NUM_SLV-1:0] sel_r, sel_r_d;
    logic [NUM_SLV-1:0] sel_low_c;

    logic [ADDR_W-1:0]  paddr_d;
    logic [DATA_W-1:0]  pwdata_d;
    logic               pwrite_d;
    logic [NUM_SLV-1:0] pselx_d;
    logic               penable_d;
    logic               hreadyout_d;
    logic               hresp_d;
    logic [DATA_W-1:0]  hrdata_d;

    // Isolate the lowest set bit so a multi-hot decode can never reach Pselx.
    assign sel_low_c = sel & (~sel + NUM_SLV'(1));

    // State and output registers.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sel_r     <= '0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Pwrite    <= 1'b0;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Hreadyout <= 1'b1;
            Hresp     <= 1'b0;
            Hrdata    <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sel_r     <= sel_r_d;
            Paddr     <= paddr_d;
            Pwdata    <= pwdata_d;
            Pwrite    <= pwrite_d;
            Pselx     <= pselx_d;
            Penable   <= penable_d;
            Hreadyout <= hreadyout_d;
            Hresp     <= hresp_d;
            Hrdata    <= hrdata_d;
        end
    end

    // Next state and next output values. Outputs are computed for the state
    // being entered, so every output reflects the current state with no
    // combinational path.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        sel_r_d     = sel_r;
        paddr_d     = Paddr;
        pwdata_d    = Pwdata;
        pwrite_d    = Pwrite;
        pselx_d     = Pselx;
        penable_d   = Penable;
        hreadyout_d = Hreadyout;
        hresp_d     = Hresp;
        hrdata_d    = Hrdata;

        case (state)
            S_IDLE: begin
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                pselx_d     = '0;
                penable_d   = 1'b0;
                if (valid) begin
                    paddr_d     = Haddr;
                    pwrite_d    = Hwrite;
                    sel_r_d     = sel_low_c;
                    hreadyout_d = 1'b0;
                    if (sel == '0) begin
                        // Unmapped: skip the APB bus entirely.
                        state_d = S_ERR1;
                        hresp_d = 1'b1;
                    end else if (Hwrite) begin
                        state_d = S_WWAIT;
                    end else begin
                        state_d = S_SETUP;
                        pselx_d = sel_low_c;
                    end
                end
            end

            // Write data arrives one cycle after the address phase.
            S_WWAIT: begin
                pwdata_d = Hwdata;
                pselx_d  = sel_r;
                state_d  = S_SETUP;
            end

            S_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = S_ACCESS;
            end

            S_ACCESS: begin
                if (Pready) begin
                    pselx_d   = '0;
                    penable_d = 1'b0;
                    if (Pslverr) begin
                        hresp_d = 1'b1;
                        state_d = S_ERR1;
                    end else begin
                        hreadyout_d = 1'b1;
                        if (!Pwrite) begin
                            hrdata_d = Prdata;
                        end
                        state_d = S_IDLE;
                    end
                end else if (WDOG_EN && (cnt == CNT_W'(CNT_LAST))) begin
                    // Watchdog: abort the stalled access.
                    pselx_d   = '0;
                    penable_d = 1'b0;
                    hresp_d   = 1'b1;
                    state_d   = S_ERR1;
                end else if (cnt != CNT_MAX) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end

            // First ERROR cycle: Hreadyout low, second cycle: Hreadyout high.
            S_ERR1: begin
                hresp_d     = 1'b1;
                hreadyout_d = 1'b1;
                state_d     = S_ERR2;
            end

            // valid is ignored here; the master cancels after an error.
            S_ERR2: begin
                hresp_d     = 1'b0;
                hreadyout_d = 1'b1;
                state_d     = S_IDLE;
            end

            default: begin
                pselx_d     = '0;
                penable_d   = 1'b0;
                hresp_d     = 1'b0;
                hreadyout_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_apb3_bridge_controller.sv
// Testbench for apb3_bridge_controller: directed and random AHB transfers
// checked cycle by cycle against a transaction-level timeline model.
module tb_apb3_bridge_controller;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned NS  = 4;
    localparam int unsigned TMO = 16;

    logic          Hclk;
    logic          Hresetn;
    logic          valid;
    logic          valid_z;
    logic          Hwrite;
    logic [AW-1:0] Haddr;
    logic [NS-1:0] sel;
    logic [DW-1:0] Hwdata;
    logic [DW-1:0] Prdata;
    logic          Pready;
    logic          Pslverr;

    logic [AW-1:0] Paddr;
    logic [DW-1:0] Pwdata;
    logic          Pwrite;
    logic [NS-1:0] Pselx;
    logic          Penable;
    logic          Hreadyout;
    logic          Hresp;
    logic [DW-1:0] Hrdata;

    logic [AW-1:0] z_Paddr;
    logic [DW-1:0] z_Pwdata;
    logic          z_Pwrite;
    logic [NS-1:0] z_Pselx;
    logic          z_Penable;
    logic          z_Hreadyout;
    logic          z_Hresp;
    logic [DW-1:0] z_Hrdata;

    apb3_bridge_controller #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT(TMO)
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Hwrite(Hwrite),
        .Haddr(Haddr), .sel(sel), .Hwdata(Hwdata), .Prdata(Prdata),
        .Pready(Pready), .Pslverr(Pslverr), .Paddr(Paddr), .Pwdata(Pwdata),
        .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable),
        .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata)
    );

    // Watchdog disabled instance; only driven through valid_z.
    apb3_bridge_controller #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_SLV(NS), .TIMEOUT(0)
    ) dut_z (
        .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid_z), .Hwrite(Hwrite),
        .Haddr(Haddr), .sel(sel), .Hwdata(Hwdata), .Prdata(Prdata),
        .Pready(Pready), .Pslverr(Pslverr), .Paddr(z_Paddr), .Pwdata(z_Pwdata),
        .Pwrite(z_Pwrite), .Pselx(z_Pselx), .Penable(z_Penable),
        .Hreadyout(z_Hreadyout), .Hresp(z_Hresp), .Hrdata(z_Hrdata)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    logic [DW-1:0] hr;   // model of the AHB read-data register

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lowest set bit of the decode, found by scanning upward.
    function automatic logic [NS-1:0] lowest(input logic [NS-1:0] s);
        logic [NS-1:0] r;
        r = '0;
        for (int i = 0; i < int'(NS); i++) begin
            if (s[i] && (r == '0)) r[i] = 1'b1;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge Hclk);
        @(negedge Hclk);
    endtask

    // One AHB transfer, entered and left at a negedge with the bridge idle.
    // The timeline is derived from the transfer description: a write spends an
    // extra cycle before SETUP; ACCESS lasts waits+1 cycles, or TMO cycles when
    // the watchdog fires; errors add a two-cycle ERROR response.
    task automatic do_txn(input string name, input bit wr, input logic [AW-1:0] addr,
                          input logic [NS-1:0] s, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd, input int waits, input bit serr);
        logic [NS-1:0] ps;
        logic [DW-1:0] hr_new;
        bit mapped, tmo, ok;
        int first_acc, n_acc, end_cyc, last;
        ps        = lowest(s);
        mapped    = (s != '0);
        first_acc = wr ? 3 : 2;
        tmo       = mapped && (TMO != 0) && (waits >= int'(TMO));
        n_acc     = tmo ? int'(TMO) : waits + 1;
        ok        = mapped && !tmo && !serr;
        end_cyc   = mapped ? first_acc + n_acc : 1;
        last      = ok ? end_cyc : end_cyc + 2;
        hr_new    = (ok && !wr) ? rd : hr;

        for (int k = 0; k <= last; k++) begin
            logic [NS-1:0] e_psel;
            bit e_pen, e_rdy, e_resp, in_apb;
            e_psel = '0; e_pen = 1'b0; e_rdy = 1'b0; e_resp = 1'b0; in_apb = 1'b0;
            if (k == 0 || k >= last) begin
                e_rdy = 1'b1;
            end else if (!ok && k == end_cyc) begin
                e_resp = 1'b1;
            end else if (!ok && k == end_cyc + 1) begin
                e_resp = 1'b1;
                e_rdy  = 1'b1;
            end else if (mapped && k >= first_acc - 1 && k < end_cyc) begin
                e_psel = ps;
                e_pen  = (k >= first_acc);
                in_apb = 1'b1;
            end

            chk($sformatf("%s psel k=%0d", name, k), 64'(Pselx), 64'(e_psel));
            chk($sformatf("%s pen k=%0d", name, k), 64'(Penable), 64'(e_pen));
            chk($sformatf("%s rdy k=%0d", name, k), 64'(Hreadyout), 64'(e_rdy));
            chk($sformatf("%s resp k=%0d", name, k), 64'(Hresp), 64'(e_resp));
            chk($sformatf("%s hrdata k=%0d", name, k), 64'(Hrdata),
                64'((k >= end_cyc) ? hr_new : hr));
            if (in_apb) begin
                chk($sformatf("%s paddr k=%0d", name, k), 64'(Paddr), 64'(addr));
                chk($sformatf("%s pwrite k=%0d", name, k), 64'(Pwrite), 64'(wr));
                if (e_pen && wr)
                    chk($sformatf("%s pwdata k=%0d", name, k), 64'(Pwdata), 64'(wd));
            end

            if (k == last) break;

            if (k == 0) begin
                valid  = 1'b1;
                Hwrite = wr;
                Haddr  = addr;
                sel    = s;
                Hwdata = DW'($urandom);
            end else begin
                // Request-side inputs are noise outside the IDLE cycle.
                valid  = 1'($urandom_range(0, 1));
                Hwrite = 1'($urandom_range(0, 1));
                Haddr  = AW'($urandom);
                sel    = NS'($urandom);
                Hwdata = wr ? wd : DW'($urandom);
            end
            if (mapped && k >= first_acc && k < first_acc + n_acc) begin
                Pready  = ((k - first_acc) >= waits);
                Pslverr = Pready ? serr : 1'($urandom_range(0, 1));
                Prdata  = Pready ? rd : DW'($urandom);
            end else begin
                Pready  = 1'($urandom_range(0, 1));
                Pslverr = 1'($urandom_range(0, 1));
                Prdata  = DW'($urandom);
            end
            tick();
        end
        valid = 1'b0;
        hr    = hr_new;
    endtask

    initial begin
        Hresetn = 1'b0;
        valid = 1'b0; valid_z = 1'b0; Hwrite = 1'b0; Haddr = '0; sel = '0;
        Hwdata = '0; Prdata = '0; Pready = 1'b0; Pslverr = 1'b0;
        hr = '0;
        repeat (2) @(negedge Hclk);

        // Reset state of both instances.
        chk("rst psel", 64'(Pselx), 64'(0));
        chk("rst pen", 64'(Penable), 64'(0));
        chk("rst rdy", 64'(Hreadyout), 64'(1));
        chk("rst resp", 64'(Hresp), 64'(0));
        chk("rst paddr", 64'(Paddr), 64'(0));
        chk("rst pwdata", 64'(Pwdata), 64'(0));
        chk("rst pwrite", 64'(Pwrite), 64'(0));
        chk("rst hrdata", 64'(Hrdata), 64'(0));
        chk("rst z", 64'({z_Pselx, z_Penable, z_Hreadyout, z_Hresp}), 64'({4'b0000, 3'b010}));
        Hresetn = 1'b1;
        tick();

        // Directed transfers.
        do_txn("rd_basic", 1'b0, 32'h40, 4'b0010, '0, 32'hDEADBEEF, 0, 1'b0);
        do_txn("wr_wait3", 1'b1, 32'h80, 4'b0001, 32'h12345678, '0, 3, 1'b0);
        do_txn("rd_slverr", 1'b0, 32'hC4, 4'b0100, '0, 32'hBADBAD00, 0, 1'b1);
        do_txn("wr_slverr", 1'b1, 32'hC8, 4'b1000, 32'h0BADF00D, '0, 2, 1'b1);
        do_txn("rd_tmo", 1'b0, 32'h10, 4'b0001, '0, 32'h11111111, 20, 1'b0);
        do_txn("rd_w15", 1'b0, 32'h14, 4'b0001, '0, 32'h22222222, 15, 1'b0);
        do_txn("rd_w16", 1'b0, 32'h18, 4'b0001, '0, 32'h33333333, 16, 1'b0);
        do_txn("unmapped", 1'b0, 32'hF00, 4'b0000, '0, 32'h44444444, 0, 1'b0);
        do_txn("b2b_rd1", 1'b0, 32'h100, 4'b0100, '0, 32'hA5A5A5A5, 0, 1'b0);
        do_txn("b2b_wr", 1'b1, 32'h104, 4'b0100, 32'h5A5A5A5A, '0, 0, 1'b0);
        do_txn("b2b_rd2", 1'b0, 32'h108, 4'b0100, '0, 32'hC3C3C3C3, 1, 1'b0);
        do_txn("multihot", 1'b0, 32'h200, 4'b0110, '0, 32'h77777777, 0, 1'b0);

        // Watchdog disabled: 100 stalled cycles with no error, then completion.
        Pready = 1'b0; Hwrite = 1'b0; sel = 4'b1000; Haddr = 32'h300;
        valid_z = 1'b1;
        tick();
        valid_z = 1'b0;
        tick();
        for (int i = 0; i < 100; i++) begin
            tick();
            chk($sformatf("tmo0 wait i=%0d", i),
                64'({z_Pselx, z_Penable, z_Hreadyout, z_Hresp}), 64'({4'b1000, 3'b100}));
        end
        Prdata = 32'hCAFEF00D; Pready = 1'b1; Pslverr = 1'b0;
        tick();
        Pready = 1'b0;
        chk("tmo0 done", 64'({z_Pselx, z_Penable, z_Hreadyout, z_Hresp}), 64'({4'b0000, 3'b010}));
        chk("tmo0 hrdata", 64'(z_Hrdata), 64'(32'hCAFEF00D));
        chk("tmo0 main idle", 64'({Pselx, Penable, Hreadyout, Hresp}), 64'({4'b0000, 3'b010}));

        // Random traffic, including unmapped, multi-hot and watchdog cases.
        for (int t = 0; t < 40; t++) begin
            int w;
            w = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 18))
                                            : int'($urandom_range(0, 4));
            do_txn($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), AW'($urandom),
                   NS'($urandom), DW'($urandom), DW'($urandom), w,
                   ($urandom_range(0, 7) == 0));
        end

        // Reset during ACCESS drops the APB bus at once.
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h400; sel = 4'b0001; Pready = 1'b0;
        tick();
        valid = 1'b0;
        tick();
        tick();
        chk("rstmid pre pen", 64'(Penable), 64'(1));
        Hresetn = 1'b0;
        #1;
        chk("rstmid psel", 64'(Pselx), 64'(0));
        chk("rstmid pen", 64'(Penable), 64'(0));
        chk("rstmid rdy", 64'(Hreadyout), 64'(1));
        chk("rstmid resp", 64'(Hresp), 64'(0));
        chk("rstmid hrdata", 64'(Hrdata), 64'(0));
        hr = '0;
        @(negedge Hclk);
        Hresetn = 1'b1;
        tick();
        do_txn("post_rst_rd", 1'b0, 32'h404, 4'b0001, '0, 32'h600DF00D, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
